// File: rtl/vga_frame_capture.sv
// vga_frame_capture: captures one active frame from a VGA-timed pixel stream into a RAM write port
//   clk, reset            pixel clock, synchronous active-high reset
//   start, continuous     arm pulse (IDLE only); re-arm after each frame when continuous = 1
//   hsync, vsync          sync inputs, polarity set by SYNC_ACTIVE_LOW
//   pixel_in              pixel colour sampled together with the syncs
//   ram_wraddr/data/wren  registered framebuffer write port, two clocks behind pixel_in
//   busy, done, err       ARM or CAPTURE; one-clock end-of-frame pulse; sticky mid-frame restart flag
module vga_frame_capture #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int H_START         = 144,
    parameter int V_START         = 35,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int ADDR_W          = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [7:0]        pixel_in,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    localparam logic        POL    = SYNC_ACTIVE_LOW != 0;
    localparam logic [10:0] H_LO   = 11'(H_START);
    localparam logic [10:0] H_HI   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LO   = 10'(V_START);
    localparam logic [9:0]  V_HI   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    state_t              state;
    logic                hs_s, vs_s, hs_p, vs_p;
    logic [7:0]          px_s;
    logic [10:0]         hcnt, h_cur, col;
    logic [9:0]          vcnt, v_cur, row;
    logic [ADDR_W-1:0]   addr;
    logic                hs_edge, vs_edge, active, cap_now, last;

    // h_cur/v_cur are the counts belonging to the sample currently in the input stage
    assign hs_edge = hs_s & ~hs_p;
    assign vs_edge = vs_s & ~vs_p;
    assign h_cur   = hs_edge ? '0 : (&hcnt ? hcnt : hcnt + 11'd1);
    assign v_cur   = vs_edge ? '0 : hs_edge ? (&vcnt ? vcnt : vcnt + 10'd1) : vcnt;
    assign col     = h_cur - H_LO;
    assign row     = v_cur - V_LO;
    assign active  = h_cur >= H_LO && h_cur < H_HI && v_cur >= V_LO && v_cur < V_HI;
    // the arming vsync sample itself belongs to the new frame
    assign cap_now = state == CAPTURE || (state == ARM && vs_edge);
    assign last    = cap_now && active && row == V_LAST && col == H_LAST;
    assign addr    = ADDR_W'(row) * ADDR_W'(H_ACTIVE) + ADDR_W'(col);
    assign busy    = state == ARM || state == CAPTURE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hs_s       <= 1'b0;
            vs_s       <= 1'b0;
            hs_p       <= 1'b0;
            vs_p       <= 1'b0;
            px_s       <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
            ram_wren   <= 1'b0;
            ram_data   <= '0;
            ram_wraddr <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            hs_s       <= hsync ^ POL;
            vs_s       <= vsync ^ POL;
            hs_p       <= hs_s;
            vs_p       <= vs_s;
            px_s       <= pixel_in;
            hcnt       <= h_cur;
            vcnt       <= v_cur;
            ram_wren   <= cap_now && active;
            ram_data   <= px_s;
            ram_wraddr <= addr;
            done       <= state == DONE;
            case (state)
                IDLE:    if (start) begin
                             state <= ARM;
                             err   <= 1'b0;
                         end
                ARM:     if (last) state <= DONE;
                         else if (vs_edge) state <= CAPTURE;
                CAPTURE: if (last) state <= DONE;
                         else if (vs_edge) err <= 1'b1;
                DONE:    state <= continuous ? ARM : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed frames checked cycle by cycle against a frame-level model
module tb_vga_frame_capture;
    localparam int HA = 4, VA = 3, HS = 2, VS = 1, AW = 19;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0;
    logic          hsync = 1'b1, vsync = 1'b1;
    logic [7:0]    pixel_in = '0;
    logic [AW-1:0] ram_wraddr;
    logic [7:0]    ram_data;
    logic          ram_wren, busy, done, err;

    vga_frame_capture #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS),
        .SYNC_ACTIVE_LOW(1), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .hsync(hsync), .vsync(vsync), .pixel_in(pixel_in),
        .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int e = 0;
    always @(posedge clk) e++;

    // expectations indexed by the clock edge after which they must be visible
    bit exp_wren[4096], exp_done[4096], exp_busy[4096], exp_err[4096];
    int exp_addr[4096], exp_data[4096];

    // frame-level model: mode 0 = not armed, 1 = armed, 2 = capturing
    int mode = 0, L = 0, p = 0, dn_idx = -1, px = 0;
    bit mbusy = 1'b0, merr = 1'b0, prev_hs = 1'b0, prev_vs = 1'b0;

    int n_chk = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0;
    int wr_log[1024];
    string lit_name[64];
    int lit_act[64], lit_exp[64];
    int lit_wr = 0, lit_rd = 0;

    task automatic check(input string nm, input int act, input int ex);
        n_chk++;
        if (act != ex) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, e, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (e >= 2 && e < 4096) begin
            check("ram_wren", int'(ram_wren), int'(exp_wren[e]));
            if (exp_wren[e]) begin
                check("ram_wraddr", int'(ram_wraddr), exp_addr[e]);
                check("ram_data", int'(ram_data), exp_data[e]);
            end
            check("done", int'(done), int'(exp_done[e]));
            check("busy", int'(busy), int'(exp_busy[e]));
            check("err", int'(err), int'(exp_err[e]));
        end
        if (ram_wren) begin
            wr_log[wr_cnt] = int'(ram_wraddr);
            wr_cnt++;
        end
        if (done) done_cnt++;
        while (lit_rd < lit_wr) begin
            check(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    task automatic lit(input string nm, input int act, input int ex);
        lit_name[lit_wr] = nm;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = ex;
        lit_wr++;
    endtask

    function automatic int bad_seq(input int b, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (wr_log[b + i] != i % (HA * VA)) bad++;
        return bad;
    endfunction

    // drive one sample (hs/vs in asserted sense) and advance the model by one pixel time
    task automatic send(input bit hs, input bit vs, input bit st, input bit rs);
        int k, row, col;
        bit vse, hse;
        @(posedge clk);
        #2;
        k = e;
        hsync = ~hs;
        vsync = ~vs;
        start = st;
        reset = rs;
        pixel_in = 8'(px);
        if (rs) begin
            exp_wren[k+1] = 1'b0;
            exp_wren[k+2] = 1'b0;
            exp_done[k+1] = 1'b0;
            exp_done[k+2] = 1'b0;
            dn_idx = -1;
            mode = 0;
            mbusy = 1'b0;
            merr = 1'b0;
        end else if (st && mode == 0) begin
            mode = 1;
            mbusy = 1'b1;
            merr = 1'b0;
        end
        exp_busy[k+1] = (k + 1 == dn_idx) ? 1'b0 : mbusy;
        exp_err[k+1]  = merr;
        if (!rs) begin
            vse = vs && !prev_vs;
            hse = hs && !prev_hs;
            L = vse ? 0 : hse ? L + 1 : L;
            p = hse ? 0 : p + 1;
            if (vse && mode == 2) merr = 1'b1;
            if (vse && mode == 1) mode = 2;
            row = L - VS;
            col = p - HS;
            if (mode == 2 && row >= 0 && row < VA && col >= 0 && col < HA) begin
                exp_wren[k+2] = 1'b1;
                exp_addr[k+2] = row * HA + col;
                exp_data[k+2] = px & 255;
                if (row == VA - 1 && col == HA - 1) begin
                    exp_done[k+3] = 1'b1;
                    dn_idx = k + 2;
                    mode = continuous ? 1 : 0;
                    mbusy = continuous;
                end
            end
        end
        prev_hs = rs ? 1'b0 : hs;
        prev_vs = rs ? 1'b0 : vs;
        px++;
    endtask

    task automatic line(input int len, input int vs_from, input int st_pos, input int rs_pos);
        for (int i = 0; i < len; i++)
            send(i == 0, vs_from >= 0 && i >= vs_from, i == st_pos, i == rs_pos);
    endtask

    task automatic frame();
        line(8, 0, -1, -1);
        repeat (4) line(8, -1, -1, -1);
    endtask

    int b, d, bad;

    initial begin
        repeat (3) send(0, 0, 0, 1);
        repeat (4) send(0, 0, 0, 0);

        b = wr_cnt; d = done_cnt;
        line(8, -1, 3, -1);
        frame();
        frame();
        lit("t1_writes", wr_cnt - b, 12);
        lit("t1_done", done_cnt - d, 1);
        lit("t1_order", bad_seq(b, 12), 0);
        lit("t1_busy_after", int'(busy), 0);

        continuous = 1'b1;
        b = wr_cnt; d = done_cnt;
        line(8, -1, 3, -1);
        frame();
        frame();
        lit("t2_busy_between", int'(busy), 1);
        continuous = 1'b0;
        frame();
        line(8, -1, -1, -1);
        lit("t2_writes", wr_cnt - b, 36);
        lit("t2_done", done_cnt - d, 3);
        lit("t2_order", bad_seq(b, 36), 0);
        lit("t2_busy_after", int'(busy), 0);

        b = wr_cnt; d = done_cnt;
        line(8, -1, 3, -1);
        line(8, 0, -1, -1);
        line(8, -1, -1, -1);
        line(8, 4, -1, -1);
        repeat (4) line(8, -1, -1, -1);
        lit("t3_writes", wr_cnt - b, 18);
        lit("t3_done", done_cnt - d, 1);
        lit("t3_err", int'(err), 1);
        lit("t3_partial", bad_seq(b, 6), 0);
        lit("t3_restart", bad_seq(b + 6, 12), 0);
        line(8, -1, 3, -1);
        lit("t3_err_cleared", int'(err), 0);

        b = wr_cnt; d = done_cnt;
        line(8, 0, -1, -1);
        line(8, -1, -1, -1);
        line(5, -1, -1, -1);
        line(8, -1, -1, -1);
        line(8, -1, -1, -1);
        bad = 0;
        for (int i = 0; i < 11; i++) if (wr_log[b + i] != (i < 7 ? i : i + 1)) bad++;
        lit("t4_writes", wr_cnt - b, 11);
        lit("t4_done", done_cnt - d, 1);
        lit("t4_addrs", bad, 0);

        b = wr_cnt; d = done_cnt;
        line(8, -1, 3, -1);
        line(8, 0, -1, -1);
        line(8, -1, -1, -1);
        line(8, -1, -1, 3);
        line(8, -1, -1, -1);
        line(8, -1, -1, -1);
        lit("t5_writes", wr_cnt - b, 4);
        lit("t5_done", done_cnt - d, 0);
        lit("t5_busy", int'(busy), 0);
        b = wr_cnt; d = done_cnt;
        line(8, -1, 3, -1);
        frame();
        lit("t5_clean_writes", wr_cnt - b, 12);
        lit("t5_clean_done", done_cnt - d, 1);
        lit("t5_clean_order", bad_seq(b, 12), 0);

        b = wr_cnt; d = done_cnt;
        line(8, -1, 3, -1);
        line(8, 0, -1, -1);
        line(8, -1, -1, -1);
        line(8, -1, 4, -1);
        repeat (3) line(8, -1, -1, -1);
        lit("t6_writes", wr_cnt - b, 12);
        lit("t6_done", done_cnt - d, 1);
        lit("t6_order", bad_seq(b, 12), 0);
        lit("t6_busy", int'(busy), 0);

        repeat (3) send(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
